arb_mux: RTL and testbench

//  N-input, W-bit registered arbitrating mux with valid/ready handshake; parametrised successor of mux2.

---
 rtl/arb_mux.sv | 201 ++++++++++++++++++++
 tb/tb_arb_mux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// N-input round-robin arbitrating mux with a one-entry registered output buffer and valid/ready handshake.
// Optional grant lock (channel pinning across transfers) is enabled by defining ARB_MUX_LOCK_EN.
module arb_mux #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    d,
  input  logic [N-1:0]      d_valid,
  output logic [N-1:0]      d_ready,
  output logic [W-1:0]      y,
  output logic [SELW-1:0]   y_sel,
  output logic              y_valid,
  input  logic              y_ready
`ifdef ARB_MUX_LOCK_EN
  ,
  input  logic [N-1:0]      lock
`endif
);

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  buf_state_t      state_r;
  buf_state_t      state_n_s;
  logic [SELW-1:0] rr_ptr_r;
  logic [SELW-1:0] next_ptr_s;
  logic [SELW-1:0] grant_idx_s;
  logic [SELW-1:0] cand_s;
  logic            grant_found_s;
  logic            accept_s;
  logic            xfer_s;
  logic [W-1:0]    sel_data_s;
  logic [W-1:0]    y_r;
  logic [SELW-1:0] y_sel_r;

`ifdef ARB_MUX_LOCK_EN
  logic            lock_active_r;
  logic [SELW-1:0] lock_ch_r;
`endif

  // Channel index base+off reduced mod N; off never exceeds N, so one subtraction suffices.
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) begin
      sum = sum - N;
    end else begin
      sum = sum;
    end
    return sum[SELW-1:0];
  endfunction

  // Round-robin search; the farthest offset is visited first so the nearest requester wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = wrap_add(rr_ptr_r, k);
      if (d_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
`ifdef ARB_MUX_LOCK_EN
    if (lock_active_r) begin
      grant_idx_s   = lock_ch_r;
      grant_found_s = d_valid[lock_ch_r];
    end else begin
      grant_idx_s   = grant_idx_s;
    end
`endif
  end

  assign accept_s = (state_r == BUF_EMPTY) || y_ready;
  assign xfer_s   = !reset && grant_found_s && accept_s;

  // One-hot accept toward the granted source only.
  always_comb begin
    d_ready = '0;
    if (xfer_s) begin
      d_ready[grant_idx_s] = 1'b1;
    end else begin
      d_ready = '0;
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx_s == SELW'(i)) begin
        sel_data_s = d[i*W +: W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output buffer occupancy: a push wins over a pop, so pop+push stays FULL with no bubble.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      BUF_EMPTY: begin
        if (xfer_s) begin
          state_n_s = BUF_FULL;
        end else begin
          state_n_s = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (xfer_s) begin
          state_n_s = BUF_FULL;
        end else if (y_ready) begin
          state_n_s = BUF_EMPTY;
        end else begin
          state_n_s = BUF_FULL;
        end
      end
      default: state_n_s = BUF_EMPTY;
    endcase
  end

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= BUF_EMPTY;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Pointer moves past the winner, except while a locked channel keeps the grant.
  always_comb begin
    next_ptr_s = rr_ptr_r;
`ifdef ARB_MUX_LOCK_EN
    if (xfer_s && !lock[grant_idx_s]) begin
      next_ptr_s = wrap_add(grant_idx_s, 1);
    end else begin
      next_ptr_s = rr_ptr_r;
    end
`else
    if (xfer_s) begin
      next_ptr_s = wrap_add(grant_idx_s, 1);
    end else begin
      next_ptr_s = rr_ptr_r;
    end
`endif
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else begin
      rr_ptr_r <= next_ptr_s;
    end
  end

  // Output data and source index; held when nothing is pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r     <= '0;
      y_sel_r <= '0;
    end else if (xfer_s) begin
      y_r     <= sel_data_s;
      y_sel_r <= grant_idx_s;
    end else begin
      y_r     <= y_r;
      y_sel_r <= y_sel_r;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  // Lock state follows the lock bit of each transfer; an unlocked transfer releases the pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active_r <= 1'b0;
      lock_ch_r     <= '0;
    end else if (xfer_s) begin
      lock_active_r <= lock[grant_idx_s];
      lock_ch_r     <= grant_idx_s;
    end else begin
      lock_active_r <= lock_active_r;
      lock_ch_r     <= lock_ch_r;
    end
  end
`endif

  assign y       = y_r;
  assign y_sel   = y_sel_r;
  assign y_valid = (state_r == BUF_FULL);

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux (W=32, N=4): directed vector table, hand sequences, and random traffic vs a queue-level model.
module tb_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N*W-1:0] d;
  logic [N-1:0]   d_valid;
  logic [N-1:0]   d_ready;
  logic [W-1:0]   y;
  logic [1:0]     y_sel;
  logic           y_valid;
  logic           y_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [N-1:0]   lock;
`endif

  int total;
  int bad;

  arb_mux #(.W(W), .N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y       (y),
    .y_sel   (y_sel),
    .y_valid (y_valid),
    .y_ready (y_ready)
`ifdef ARB_MUX_LOCK_EN
    ,
    .lock    (lock)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  dv;
    logic        yr;
    logic [3:0]  dr;
    logic        yv;
    logic [1:0]  sel;
    logic [31:0] yd;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle (called at posedge+1): check d_ready before the edge, outputs after it.
  task automatic apply(input string nm, input logic r, input logic [3:0] dv, input logic yr,
                       input logic [3:0] edr, input logic eyv, input logic [1:0] esel,
                       input logic [31:0] ey);
    reset   = r;
    d_valid = dv;
    y_ready = yr;
    #3;
    chk({nm, ".d_ready"}, {28'd0, d_ready}, {28'd0, edr});
    @(posedge clk);
    #1;
    chk({nm, ".y_valid"}, {31'd0, y_valid}, {31'd0, eyv});
    chk({nm, ".y_sel"}, {30'd0, y_sel}, {30'd0, esel});
    chk({nm, ".y"}, y, ey);
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N; i++) begin
      d[i*W +: W] = 32'hA0 + 32'(i);
    end
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic lapply(input string nm, input logic [3:0] lk, input logic [3:0] dv,
                        input logic [3:0] edr, input logic eyv, input logic [1:0] esel,
                        input logic [31:0] ey);
    lock = lk;
    apply(nm, 1'b0, dv, 1'b1, edr, eyv, esel, ey);
  endtask
`endif

  // Random-phase reference model state
  int          m_ptr;
  logic        m_full;
  logic [31:0] m_y;
  int          m_sel;
  int          g;
  int          idx;
  logic        r_r;
  logic [3:0]  r_dv;
  logic        r_yr;
  logic [3:0]  e_dr;

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    d_valid = 4'b0000;
    y_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
    lock    = 4'b0000;
`endif
    set_default_data();
    @(posedge clk);
    #1;

    // Directed table: reset, full-rate round robin, wrap-around, stall, reset while FULL
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[9]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[10] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[11] = '{1'b0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA2};
    tbl[14] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[15] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3};
    tbl[16] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[17] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[18] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    for (int i = 0; i < 19; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].dv, tbl[i].yr,
            tbl[i].dr, tbl[i].yv, tbl[i].sel, tbl[i].yd);
    end

    // Single requester held off by downstream back-pressure, then drained
    apply("stall_rst", 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
    d[2*W +: W] = 32'h1234;
    apply("stall_push", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h1234);
    d[2*W +: W] = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      apply($sformatf("stall_hold%0d", i), 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 32'h1234);
    end
    apply("stall_swap", 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h5678);
    apply("stall_drain", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h5678);

`ifdef ARB_MUX_LOCK_EN
    // ch1 holds the grant over three beats (one idle gap), then round robin resumes from ch2
    set_default_data();
    apply("lk_rst", 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
    lapply("lk_a", 4'b0000, 4'b0001, 4'b0001, 1'b1, 2'd0, 32'hA0);
    lapply("lk_b", 4'b0010, 4'b1011, 4'b0010, 1'b1, 2'd1, 32'hA1);
    lapply("lk_idle", 4'b0010, 4'b1001, 4'b0000, 1'b0, 2'd1, 32'hA1);
    lapply("lk_c", 4'b0010, 4'b1011, 4'b0010, 1'b1, 2'd1, 32'hA1);
    lapply("lk_d", 4'b0000, 4'b1011, 4'b0010, 1'b1, 2'd1, 32'hA1);
    lapply("lk_e", 4'b0000, 4'b1001, 4'b1000, 1'b1, 2'd3, 32'hA3);
    lapply("lk_f", 4'b0000, 4'b1001, 4'b0001, 1'b1, 2'd0, 32'hA0);
    lock = 4'b0000;
`endif

    // Random traffic against a behavioural model of the buffer and rotating priority
    apply("rnd_rst", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0);
    m_ptr  = 0;
    m_full = 1'b0;
    m_y    = 32'h0;
    m_sel  = 0;
    for (int c = 0; c < 400; c++) begin
      r_r  = ($urandom_range(0, 31) == 0);
      r_dv = 4'($urandom);
      r_yr = 1'($urandom);
      for (int ch = 0; ch < N; ch++) begin
        d[ch*W +: W] = $urandom;
      end
      reset   = r_r;
      d_valid = r_dv;
      y_ready = r_yr;
      #3;
      g    = -1;
      e_dr = 4'b0000;
      if (!r_r && (!m_full || r_yr)) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && r_dv[idx]) g = idx;
        end
      end
      if (g >= 0) e_dr[g] = 1'b1;
      chk("rnd.d_ready", {28'd0, d_ready}, {28'd0, e_dr});
      if (r_r) begin
        m_ptr  = 0;
        m_full = 1'b0;
        m_y    = 32'h0;
        m_sel  = 0;
      end else if (g >= 0) begin
        m_y    = d[g*W +: W];
        m_sel  = g;
        m_full = 1'b1;
        m_ptr  = (g + 1) % N;
      end else if (m_full && r_yr) begin
        m_full = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rnd.y_valid", {31'd0, y_valid}, {31'd0, m_full});
      chk("rnd.y_sel", {30'd0, y_sel}, 32'(m_sel));
      chk("rnd.y", y, m_y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
